// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences ALU, register file and unified memory per instruction.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a terminal TRAP state.
module multicycle_ctrl #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic [1:0]           ALUOp,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  state_t               r_state;
  state_t               w_next;
  ctl_t                 r_ctl;
  logic [INSTRET_W-1:0] r_instret;
  logic                 w_retire;
  logic                 w_unused;

  // Moore control word for a state; registered against the next state so outputs leave flops.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  // Only completing states retire; an unknown-op NOP returns from DECODE and is not counted.
  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                     (r_state == S_ALUWB) || (r_state == S_BRANCH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctl     <= ctl_of(S_FETCH);
      r_instret <= '0;
    end else begin
      r_state   <= w_next;
      r_ctl     <= ctl_of(w_next);
      if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_illegal <= 1'b0;
    else if (w_next == S_TRAP) r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  // Immediate format follows the opcode directly so DECODE can form the branch/jump target.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  assign IRWrite   = r_ctl.fetch & mem_ready;
  assign PCWrite   = (r_ctl.fetch & mem_ready) | r_ctl.pc_update |
                     (r_ctl.branch & (Zero ^ funct3[0]));
  assign AdrSrc    = r_ctl.adr_src;
  assign MemWrite  = r_ctl.mem_write;
  assign ResultSrc = r_ctl.result_src;
  assign ALUSrcA   = r_ctl.alu_src_a;
  assign ALUSrcB   = r_ctl.alu_src_b;
  assign RegWrite  = r_ctl.reg_write;
  assign ALUOp     = r_ctl.alu_op;
  assign instret   = r_instret;

  assign w_unused  = ^funct3[2:1];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle against hand-built control words.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
  logic [31:0] instret;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = 32'd0;

  multicycle_ctrl #(.INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite}_ResultSrc_ALUSrcA_ALUSrcB_RegWrite_ALUOp
  logic [12:0] w_obs;
  assign w_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ALUOp};

  localparam logic [12:0] E_F1   = 13'b1001_10_00_10_0_00;
  localparam logic [12:0] E_F0   = 13'b0000_10_00_10_0_00;
  localparam logic [12:0] E_DEC  = 13'b0000_00_01_01_0_00;
  localparam logic [12:0] E_EXR  = 13'b0000_00_10_00_0_10;
  localparam logic [12:0] E_EXI  = 13'b0000_00_10_01_0_10;
  localparam logic [12:0] E_AWB  = 13'b0000_00_00_00_1_00;
  localparam logic [12:0] E_MADR = 13'b0000_00_10_01_0_00;
  localparam logic [12:0] E_MRD  = 13'b0100_00_00_00_0_00;
  localparam logic [12:0] E_MWB  = 13'b0000_01_00_00_1_00;
  localparam logic [12:0] E_MWR  = 13'b0110_00_00_00_0_00;
  localparam logic [12:0] E_BRT  = 13'b1000_00_10_00_0_01;
  localparam logic [12:0] E_BRN  = 13'b0000_00_10_00_0_01;
  localparam logic [12:0] E_JAL  = 13'b1000_00_01_10_0_00;
  localparam logic [12:0] E_TRAP = 13'b0000_00_00_00_0_00;

  task automatic step(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1);
    n_checks++;
    if (w_obs !== E_F1) begin
      n_errors++; $display("FAIL reset_ctl got %b want %b", w_obs, E_F1);
    end
    n_checks++;
    if (instret !== 32'd0 || illegal !== 1'b0) begin
      n_errors++; $display("FAIL reset_cnt instret=%0d illegal=%b want 0/0", instret, illegal);
    end
    mem_ready = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_alu(input logic [6:0] opc, input logic [12:0] exec_word, input string name);
    logic [12:0] exp [5];
    logic        rdy [5];
    exp = '{E_F1, E_DEC, exec_word, E_AWB, E_F0};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = opc;
    for (int i = 0; i < 5; i++) begin
      step(rdy[i]);
      n_checks++;
      if (w_obs !== exp[i]) begin
        n_errors++; $display("FAIL %s step%0d ctl got %b want %b", name, i, w_obs, exp[i]);
      end
    end
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (instret !== exp_instret) begin
      n_errors++; $display("FAIL %s instret got %0d want %0d", name, instret, exp_instret);
    end
  endtask

  task automatic test_load();
    logic [12:0] exp [9];
    logic        rdy [9];
    exp = '{E_F1, E_DEC, E_MADR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB, E_F0};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    op = 7'b0000011;
    for (int i = 0; i < 9; i++) begin
      step(rdy[i]);
      n_checks++;
      if (w_obs !== exp[i]) begin
        n_errors++; $display("FAIL lw step%0d ctl got %b want %b", i, w_obs, exp[i]);
      end
    end
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (instret !== exp_instret) begin
      n_errors++; $display("FAIL lw instret got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_store();
    logic [12:0] exp [9];
    logic        rdy [9];
    int          mw_cycles;
    exp = '{E_F0, E_F0, E_F1, E_DEC, E_MADR, E_MWR, E_MWR, E_MWR, E_F0};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mw_cycles = 0;
    op = 7'b0100011;
    for (int i = 0; i < 9; i++) begin
      step(rdy[i]);
      if (MemWrite === 1'b1) mw_cycles++;
      n_checks++;
      if (w_obs !== exp[i]) begin
        n_errors++; $display("FAIL sw step%0d ctl got %b want %b", i, w_obs, exp[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (ImmSrc !== 2'b01) begin
          n_errors++; $display("FAIL sw ImmSrc got %b want 01", ImmSrc);
        end
      end
    end
    n_checks++;
    if (mw_cycles != 3) begin
      n_errors++; $display("FAIL sw MemWrite cycles got %0d want 3", mw_cycles);
    end
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (instret !== exp_instret) begin
      n_errors++; $display("FAIL sw instret got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic z, input logic [12:0] br_word);
    logic [12:0] exp [4];
    logic        rdy [4];
    exp = '{E_F1, E_DEC, br_word, E_F0};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    op = 7'b1100011;
    funct3 = f3;
    Zero = z;
    for (int i = 0; i < 4; i++) begin
      step(rdy[i]);
      n_checks++;
      if (w_obs !== exp[i]) begin
        n_errors++; $display("FAIL br f3=%b z=%b step%0d ctl got %b want %b", f3, z, i, w_obs, exp[i]);
      end
      if (i == 1) begin
        n_checks++;
        if (ImmSrc !== 2'b10) begin
          n_errors++; $display("FAIL br ImmSrc got %b want 10", ImmSrc);
        end
      end
    end
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (instret !== exp_instret) begin
      n_errors++; $display("FAIL br instret got %0d want %0d", instret, exp_instret);
    end
    funct3 = 3'b0;
    Zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [12:0] exp [5];
    logic        rdy [5];
    exp = '{E_F1, E_DEC, E_JAL, E_AWB, E_F0};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = 7'b1101111;
    for (int i = 0; i < 5; i++) begin
      step(rdy[i]);
      n_checks++;
      if (w_obs !== exp[i]) begin
        n_errors++; $display("FAIL jal step%0d ctl got %b want %b", i, w_obs, exp[i]);
      end
      if (i == 1) begin
        n_checks++;
        if (ImmSrc !== 2'b11) begin
          n_errors++; $display("FAIL jal ImmSrc got %b want 11", ImmSrc);
        end
      end
    end
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (instret !== exp_instret) begin
      n_errors++; $display("FAIL jal instret got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_illegal();
    op = 7'b0000000;
    step(1'b1);
    step(1'b1);
    n_checks++;
    if (w_obs !== E_DEC || ImmSrc !== 2'b00) begin
      n_errors++; $display("FAIL ill decode ctl got %b imm %b want %b imm 00", w_obs, ImmSrc, E_DEC);
    end
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      n_checks++;
      if (w_obs !== E_TRAP || illegal !== 1'b1) begin
        n_errors++; $display("FAIL ill trap%0d ctl got %b illegal %b want %b illegal 1", i, w_obs, illegal, E_TRAP);
      end
    end
    n_checks++;
    if (instret !== exp_instret) begin
      n_errors++; $display("FAIL ill trap instret got %0d want %0d", instret, exp_instret);
    end
    reset = 1'b1;
    #1;
    mem_ready = 1'b0;
    reset = 1'b0;
    exp_instret = 32'd0;
    step(1'b0);
    n_checks++;
    if (w_obs !== E_F0 || illegal !== 1'b0) begin
      n_errors++; $display("FAIL ill recover ctl got %b illegal %b want %b illegal 0", w_obs, illegal, E_F0);
    end
`else
    step(1'b0);
    n_checks++;
    if (w_obs !== E_F0 || illegal !== 1'b0) begin
      n_errors++; $display("FAIL ill nop ctl got %b illegal %b want %b illegal 0", w_obs, illegal, E_F0);
    end
    n_checks++;
    if (instret !== exp_instret) begin
      n_errors++; $display("FAIL ill nop instret got %0d want %0d", instret, exp_instret);
    end
`endif
  endtask

  task automatic test_reset_mid_store();
    op = 7'b0100011;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    n_checks++;
    if (w_obs !== E_MWR) begin
      n_errors++; $display("FAIL rst_mid pre ctl got %b want %b", w_obs, E_MWR);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0 || w_obs !== E_F0) begin
      n_errors++; $display("FAIL rst_mid async ctl got %b want %b", w_obs, E_F0);
    end
    n_checks++;
    if (instret !== 32'd0) begin
      n_errors++; $display("FAIL rst_mid instret got %0d want 0", instret);
    end
    #1;
    reset = 1'b0;
    step(1'b0);
    n_checks++;
    if (w_obs !== E_F0 || instret !== 32'd0) begin
      n_errors++; $display("FAIL rst_mid post ctl got %b instret %0d want %b/0", w_obs, instret, E_F0);
    end
  endtask

  initial begin
    test_reset();
    test_alu(7'b0110011, E_EXR, "add");
    test_alu(7'b0010011, E_EXI, "addi");
    test_load();
    test_store();
    test_branch(3'b000, 1'b1, E_BRT);
    test_branch(3'b001, 1'b1, E_BRN);
    test_branch(3'b001, 1'b0, E_BRT);
    test_jal();
    test_illegal();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
